modulation_generator: RTL and testbench
=======================================

# modulation_generator

Generates the ASK, BPSK, FSK and raw-LFSR 12-bit waveforms that feed the modulation-select multiplexer of the signal display path. It consumes the carrier samples from the DDS stage and owns the pseudo-random data source: a 5-bit maximal-length LFSR that is advanced once per bit period of `SAMPLES_PER_BIT` carrier samples. All outputs are registered and qualified by a one-cycle `out_valid` pulse.

## Interface
- `LFSR_SEED`, default 5'b00001: LFSR load value on reset. Zero is illegal; if zero, the block loads 5'b00001.
- `SAMPLES_PER_BIT`, default 16: carrier samples per data bit. Legal range is 2..1024.
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: reset, synchronous, active-low.
- `sample_en` input 1: one-cycle strobe marking a new valid carrier sample on `carrier` and `carrier_fsk`.
- `carrier` input 12: unsigned offset-binary carrier (midscale 12'h800). Used for ASK, BPSK and FSK space.
- `carrier_fsk` input 12: second-frequency carrier, same format. Used for FSK mark.
- `ask` output 12: ASK sample.
- `bpsk` output 12: BPSK sample.
- `fsk` output 12: FSK sample.
- `lfsr_wave` output 12: current data bit as a full-scale level.
- `lfsr_bit` output 1: current data bit.
- `bit_strobe` output 1: one-cycle pulse when the data bit advances.
- `out_valid` output 1: one-cycle pulse marking new `ask`/`bpsk`/`fsk`/`lfsr_wave` values.

## Operation
- LFSR state `q[4:0]` is Fibonacci, shifting left: next `q` = {q[3:0], q[4]^q[2]} (polynomial x^5+x^3+1, period 31). `lfsr_bit` = q[0].
- From seed 00001 the states are 00001, 00010, 00100, 01001, 10010, 00101, 01011, … The corresponding `lfsr_bit` sequence is 1,0,0,1,0,1,1,…
- Lock-up guard: if `q` is ever 00000, it reloads 00001 on the next edge.
- The sample counter `cnt` has width clog2(`SAMPLES_PER_BIT`) and changes only on `sample_en`:
  - If `cnt` == `SAMPLES_PER_BIT`-1, `cnt` wraps to 0, the LFSR advances and `bit_strobe` is 1 for the following cycle.
  - Otherwise `cnt` increments.
- Mapping, evaluated on the `sample_en` cycle using the bit in effect before any same-edge advance:
  - `ask` = bit ? `carrier` : 12'h800.
  - `bpsk` = bit ? `carrier` : 12'hFFF − `carrier` (bitwise invert, mirror about midscale; no overflow possible).
  - `fsk` = bit ? `carrier_fsk` : `carrier`.
  - `lfsr_wave` = bit ? 12'hFFF : 12'h000.
- The sample that wraps `cnt` is therefore the last sample of the old bit. The next `sample_en` uses the new bit.
- With no `sample_en`, outputs hold their last values, and `cnt` and the LFSR hold.
- Back-to-back `sample_en` (every cycle) is legal and is processed every cycle.

## Timing
- Latency: outputs and `out_valid` update on the clock edge that samples `sample_en` = 1, so they are visible one cycle after the strobe.
- `bit_strobe` coincides with the `out_valid` of the wrapping sample. On that cycle `lfsr_bit` already shows the new bit.
- Reset values:
  - `ask`, `bpsk`, `fsk` = 12'h800; `lfsr_wave` = 12'h000.
  - `out_valid` = 0, `bit_strobe` = 0.
  - `q` = seed, so `lfsr_bit` = seed[0]; `cnt` = 0.
- Reset has priority over `sample_en` on the same edge.
- Reset asserted mid-bit discards the partial count. The first bit after release lasts a full `SAMPLES_PER_BIT` samples.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `sample_en` toggling → all outputs at their reset values and `out_valid`=0 throughout. After release, `lfsr_bit`=1.
- Mapping, `SAMPLES_PER_BIT`=4, `carrier`=12'h123, `carrier_fsk`=12'h456, bit=1 → `ask`=123, `bpsk`=123, `fsk`=456, `lfsr_wave`=FFF. After the bit changes to 0 → `ask`=800, `bpsk`=EDC, `fsk`=123, `lfsr_wave`=000.
- Bit timing, `SAMPLES_PER_BIT`=4, continuous `sample_en` → `bit_strobe` every 4th `out_valid`; `lfsr_bit` sequence 1,0,0,1,0,1,1.
- Sparse strobes: `sample_en` every 5th cycle → outputs and `cnt` change only after strobes; `out_valid` pulses are exactly one cycle each.
- Period: run 31×`SAMPLES_PER_BIT` samples → the LFSR state returns to 00001, all 31 nonzero states are visited, and the state is never 00000.
- Reset mid-bit: reset after 2 of 4 samples → after release, the first `bit_strobe` follows the 4th new sample and `lfsr_bit` restarts at 1.

Source files
------------

// File: rtl/modulation_generator.sv
// modulation_generator: ASK/BPSK/FSK/raw-LFSR 12-bit waveforms keyed by a 5-bit LFSR data source
// Ports: clk, rst_n (sync, active-low); sample_en strobe with carrier / carrier_fsk samples in;
//        registered ask, bpsk, fsk, lfsr_wave with out_valid pulse; lfsr_bit and bit_strobe out.
module modulation_generator #(
    parameter logic [4:0] LFSR_SEED       = 5'b00001,
    parameter int         SAMPLES_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_en,
    input  logic [11:0] carrier,
    input  logic [11:0] carrier_fsk,
    output logic [11:0] ask,
    output logic [11:0] bpsk,
    output logic [11:0] fsk,
    output logic [11:0] lfsr_wave,
    output logic        lfsr_bit,
    output logic        bit_strobe,
    output logic        out_valid
);
    localparam int              CW   = $clog2(SAMPLES_PER_BIT);
    localparam logic [4:0]      SEED = (LFSR_SEED == 5'd0) ? 5'd1 : LFSR_SEED;
    localparam logic [CW-1:0]   LAST = CW'(SAMPLES_PER_BIT - 1);
    logic [4:0]    q, q_nxt;
    logic [CW-1:0] cnt;
    logic          wrap, b;
    assign b        = q[0];
    assign lfsr_bit = q[0];
    // The all-zero state is reloaded unconditionally so the LFSR can never lock up.
    always_comb begin
        wrap  = sample_en && (cnt == LAST);
        q_nxt = (q == 5'd0) ? 5'd1 : wrap ? {q[3:0], q[4] ^ q[2]} : q;
    end
    // Mapping uses the bit before any same-edge advance, so the wrapping sample closes the old bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q          <= SEED;
            cnt        <= '0;
            ask        <= 12'h800;
            bpsk       <= 12'h800;
            fsk        <= 12'h800;
            lfsr_wave  <= 12'h000;
            out_valid  <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            q          <= q_nxt;
            out_valid  <= sample_en;
            bit_strobe <= wrap;
            if (sample_en) begin
                cnt       <= wrap ? '0 : cnt + CW'(1);
                ask       <= b ? carrier : 12'h800;
                bpsk      <= b ? carrier : ~carrier;
                fsk       <= b ? carrier_fsk : carrier;
                lfsr_wave <= b ? 12'hFFF : 12'h000;
            end
        end
    end
endmodule

// File: tb/tb_modulation_generator.sv
// tb_modulation_generator: randomized self-checking bench against a behavioural model of modulation_generator
module tb_modulation_generator;
    localparam int SPB = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [11:0] carrier = 12'h0;
    logic [11:0] carrier_fsk = 12'h0;
    logic [11:0] ask, bpsk, fsk, lfsr_wave;
    logic        lfsr_bit, bit_strobe, out_valid;
    int checks = 0;
    int errors = 0;
    // behavioural model state
    int m_q = 1;
    int m_cnt = 0;
    int e_ask = 'h800, e_bpsk = 'h800, e_fsk = 'h800, e_wave = 0;
    int e_ov = 0, e_bs = 0;
    // observation bookkeeping
    int strobes = 0;
    int strobe_at = 0;
    int samples = 0;
    int bits_seen[$];

    modulation_generator #(.LFSR_SEED(5'b00001), .SAMPLES_PER_BIT(SPB)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .carrier(carrier),
        .carrier_fsk(carrier_fsk), .ask(ask), .bpsk(bpsk), .fsk(fsk),
        .lfsr_wave(lfsr_wave), .lfsr_bit(lfsr_bit), .bit_strobe(bit_strobe),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the spec rules, then compare every output.
    task automatic step(input logic rs, input logic en, input logic [11:0] c, input logic [11:0] cf);
        int bt;
        rst_n = rs;
        sample_en = en;
        carrier = c;
        carrier_fsk = cf;
        @(posedge clk);
        #1;
        if (!rs) begin
            m_q = 1; m_cnt = 0;
            e_ask = 'h800; e_bpsk = 'h800; e_fsk = 'h800; e_wave = 0;
            e_ov = 0; e_bs = 0;
        end else if (en) begin
            bt = m_q & 1;
            e_ask  = bt ? int'(c) : 'h800;
            e_bpsk = bt ? int'(c) : 4095 - int'(c);
            e_fsk  = bt ? int'(cf) : int'(c);
            e_wave = bt ? 4095 : 0;
            e_ov = 1;
            e_bs = (m_cnt == SPB - 1) ? 1 : 0;
            if (m_cnt == SPB - 1) begin
                m_cnt = 0;
                m_q = ((m_q << 1) | (((m_q >> 4) ^ (m_q >> 2)) & 1)) & 31;
            end else
                m_cnt++;
            samples++;
        end else begin
            e_ov = 0; e_bs = 0;
        end
        chk("ask", 32'(ask), 32'(e_ask));
        chk("bpsk", 32'(bpsk), 32'(e_bpsk));
        chk("fsk", 32'(fsk), 32'(e_fsk));
        chk("lfsr_wave", 32'(lfsr_wave), 32'(e_wave));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("bit_strobe", 32'(bit_strobe), 32'(e_bs));
        chk("lfsr_bit", 32'(lfsr_bit), 32'(m_q & 1));
        if (bit_strobe === 1'b1) begin
            strobes++;
            strobe_at = samples;
            bits_seen.push_back(int'(lfsr_bit));
        end
    endtask

    task automatic rnd_step(input logic rs, input logic en);
        step(rs, en, 12'($urandom), 12'($urandom));
    endtask

    initial begin
        int exp_bits[7] = '{1, 0, 0, 1, 0, 1, 1};
        logic [4:0] h;
        logic [31:0] visited;
        int nz;

        // reset held 3 cycles with sample_en toggling
        for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'(i & 1));
        chk("reset_bit", 32'(lfsr_bit), 32'd1);

        // mapping with fixed carriers: bit 1 for the first 4 samples, then bit 0
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 12'h123, 12'h456);
        step(1'b1, 1'b1, 12'h123, 12'h456);
        chk("map0_ask", 32'(ask), 32'h800);
        chk("map0_bpsk", 32'(bpsk), 32'hEDC);
        chk("map0_fsk", 32'(fsk), 32'h123);
        chk("map0_wave", 32'(lfsr_wave), 32'h000);

        // bit timing with continuous strobes from a fresh reset
        rnd_step(1'b0, 1'b1);
        bits_seen.delete();
        bits_seen.push_back(int'(lfsr_bit));
        strobes = 0;
        for (int i = 0; i < 6 * SPB; i++) rnd_step(1'b1, 1'b1);
        chk("strobe_count", 32'(strobes), 32'd6);
        for (int i = 0; i < 7; i++) chk("bit_seq", 32'(bits_seen[i]), 32'(exp_bits[i]));

        // sparse strobes: sample_en every 5th cycle
        for (int i = 0; i < 40; i++) rnd_step(1'b1, 1'(i % 5 == 4));

        // full period from reset: reconstruct states from the observed bit stream
        rnd_step(1'b0, 1'b0);
        bits_seen.delete();
        for (int i = 0; i < 31 * SPB; i++) rnd_step(1'b1, 1'b1);
        chk("period_bits", 32'(bits_seen.size()), 32'd31);
        h = 5'b00001;
        visited = '0;
        nz = 1;
        foreach (bits_seen[i]) begin
            h = {h[3:0], bits_seen[i][0]};
            if (h == 5'd0) nz = 0;
            visited[h] = 1'b1;
        end
        chk("period_state", 32'(h), 32'd1);
        chk("period_visited", 32'($countones(visited)), 32'd31);
        chk("period_nonzero", 32'(nz), 32'd1);

        // reset mid-bit after 2 of 4 samples
        rnd_step(1'b1, 1'b1);
        rnd_step(1'b1, 1'b1);
        rnd_step(1'b0, 1'b0);
        chk("midrst_bit", 32'(lfsr_bit), 32'd1);
        samples = 0;
        strobes = 0;
        for (int i = 0; i < SPB; i++) rnd_step(1'b1, 1'b1);
        chk("midrst_strobes", 32'(strobes), 32'd1);
        chk("midrst_at", 32'(strobe_at), 32'(SPB));

        // randomized tail: random strobes and occasional resets
        for (int i = 0; i < 300; i++) rnd_step(1'($urandom_range(0, 49) != 0), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
